// File: rtl/mem_arbiter_pkg.sv
// Command and state encodings shared by the RAM arbiter and the CPU state machine.
package mem_arbiter_pkg;

    localparam logic [1:0] MNone  = 2'b00;
    localparam logic [1:0] MRead  = 2'b01;
    localparam logic [1:0] MWrite = 2'b10;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StIssue = 2'b01,
        StWait  = 2'b10,
        StDone  = 2'b11
    } arb_state_e;

    // 2'b11 is reserved and never counts as a request.
    function automatic logic is_req(input logic [1:0] cmd);
        return (cmd == MRead) || (cmd == MWrite);
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_select.sv
// Two-way round-robin pick: the master that did not own the last transaction wins ties.
module mem_arbiter_rr_select (
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       grant,
    output logic       winner
);

    logic other;

    assign other = ~last_owner;

    always_comb begin
        grant  = |req;
        winner = 1'b0;
        if (req[other]) begin
            winner = other;
        end else if (req[last_owner]) begin
            winner = last_owner;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between two masters, one transaction at a time, with a
// round-robin grant, configurable read latency and a one-cycle completion ack.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned AW     = 9,
    parameter int unsigned DW     = 16,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    m0_cmd,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_ack,
    input  logic [1:0]    m1_cmd,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_ack,
    output logic [1:0]    mem_cmd,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
);

    // WAIT runs RD_LAT cycles, so the counter starts one below the latency.
    localparam logic [2:0] CntLoad = (RD_LAT == 0) ? 3'd0 : 3'(RD_LAT - 1);

    arb_state_e    state_q, state_d;
    logic [1:0]    cmd_q, cmd_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [DW-1:0] m0_rdata_q, m0_rdata_d;
    logic [DW-1:0] m1_rdata_q, m1_rdata_d;
    logic          owner_q, owner_d;
    logic          last_owner_q, last_owner_d;

    logic [1:0]    req;
    logic          grant;
    logic          winner;
    logic          capture;

    assign req = {is_req(m1_cmd), is_req(m0_cmd)};

    mem_arbiter_rr_select u_rr_select (
        .req        (req),
        .last_owner (last_owner_q),
        .grant      (grant),
        .winner     (winner)
    );

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        capture      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    state_d = StIssue;
                    owner_d = winner;
                    cmd_d   = winner ? m1_cmd   : m0_cmd;
                    addr_d  = winner ? m1_addr  : m0_addr;
                    wdata_d = winner ? m1_wdata : m0_wdata;
                end
            end
            StIssue: begin
                if ((cmd_q == MRead) && (RD_LAT != 0)) begin
                    state_d = StWait;
                    cnt_d   = CntLoad;
                end else begin
                    // Zero-latency reads return data combinationally during ISSUE.
                    capture = (cmd_q == MRead);
                    state_d = StDone;
                end
            end
            StWait: begin
                if (cnt_q == 3'd0) begin
                    capture = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StDone: begin
                last_owner_d = owner_q;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Only the owner's read-data register ever changes.
    always_comb begin
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        if (capture) begin
            if (owner_q) begin
                m1_rdata_d = mem_rdata;
            end else begin
                m0_rdata_d = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            cmd_q        <= MNone;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= 3'd0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
        end
    end

    always_comb begin
        mem_cmd   = MNone;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if ((state_q == StIssue) || (state_q == StWait)) begin
            mem_cmd = cmd_q;
        end
    end

    assign m0_ack   = (state_q == StDone) && !owner_q;
    assign m1_ack   = (state_q == StDone) && owner_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;
    assign busy     = (state_q != StIdle);
    assign owner    = owner_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            assert (!(m0_ack && m1_ack));
            assert (mem_cmd != 2'b11);
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter at read latencies 0, 1 and 3: directed cases plus randomized masters,
// checked every cycle against a transaction-level model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int unsigned AW    = 9;
    localparam int unsigned DW    = 16;
    localparam int unsigned Words = 1 << AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input int lat, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL L=%0d %s: got %0h want %0h at %0t", lat, name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] init_word(input int a);
        return 16'(a * 40503 + 4660);
    endfunction

    function automatic logic [1:0] rnd_cmd();
        int r;
        r = $urandom_range(0, 9);
        if (r < 4) return MNone;
        if (r < 7) return MRead;
        if (r < 9) return MWrite;
        return 2'b11;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int unsigned L    = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
        localparam int unsigned PIdx = (L == 0) ? 0 : L - 1;

        logic          rst_n;
        logic [1:0]    m0_cmd, m1_cmd, mem_cmd;
        logic [AW-1:0] m0_addr, m1_addr, mem_addr;
        logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, mem_wdata, mem_rdata;
        logic          m0_ack, m1_ack, busy, owner;

        logic [DW-1:0] ram  [Words];
        logic [DW-1:0] pipe [8];
        int            cyc = 0;
        bit            fin = 1'b0;

        // Transaction-level model state
        bit            mvalid = 1'b0;
        bit            pend   = 1'b0;
        int            p_grant = 0;
        int            p_ack   = 0;
        logic          p_own   = 1'b0;
        logic [1:0]    p_cmd   = MNone;
        logic [AW-1:0] p_addr  = '0;
        logic [DW-1:0] p_wd    = '0;
        logic [DW-1:0] p_rd    = '0;
        logic          m_last  = 1'b1;
        logic          m_own   = 1'b0;
        logic [DW-1:0] m_rd   [2];
        logic [DW-1:0] shadow [Words];

        mem_arbiter #(
            .AW     (AW),
            .DW     (DW),
            .RD_LAT (L)
        ) dut (
            .clk       (clk),
            .reset     (rst_n),
            .m0_cmd    (m0_cmd),
            .m0_addr   (m0_addr),
            .m0_wdata  (m0_wdata),
            .m0_rdata  (m0_rdata),
            .m0_ack    (m0_ack),
            .m1_cmd    (m1_cmd),
            .m1_addr   (m1_addr),
            .m1_wdata  (m1_wdata),
            .m1_rdata  (m1_rdata),
            .m1_ack    (m1_ack),
            .mem_cmd   (mem_cmd),
            .mem_addr  (mem_addr),
            .mem_wdata (mem_wdata),
            .mem_rdata (mem_rdata),
            .busy      (busy),
            .owner     (owner)
        );

        // RAM: write at the end of the command cycle, read data after L cycles of pipeline.
        assign mem_rdata = (L == 0) ? ram[mem_addr] : pipe[PIdx];

        initial begin
            logic [1:0]    s_cmd;
            logic [AW-1:0] s_addr;
            logic [DW-1:0] s_wd;
            for (int a = 0; a < int'(Words); a++) ram[a] = init_word(a);
            for (int k = 0; k < 8; k++) pipe[k] = DW'($urandom);
            forever begin
                @(negedge clk);
                s_cmd  = mem_cmd;
                s_addr = mem_addr;
                s_wd   = mem_wdata;
                @(posedge clk);
                #1;
                for (int k = 7; k > 0; k--) pipe[k] = pipe[k-1];
                pipe[0] = (s_cmd == MRead) ? ram[s_addr] : DW'($urandom);
                if (s_cmd == MWrite) ram[s_addr] = s_wd;
            end
        end

        // Model: one transaction at a time; grant when idle, ack 2 (+L for reads) cycles later.
        initial begin
            logic r0, r1, w;
            m_rd[0] = '0;
            m_rd[1] = '0;
            for (int a = 0; a < int'(Words); a++) shadow[a] = init_word(a);
            forever begin
                @(posedge clk);
                if (pend && p_cmd == MWrite && cyc == p_grant + 1) shadow[p_addr] = p_wd;
                if (!rst_n) begin
                    pend    = 1'b0;
                    m_own   = 1'b0;
                    m_last  = 1'b1;
                    m_rd[0] = '0;
                    m_rd[1] = '0;
                    mvalid  = 1'b1;
                end else if (mvalid) begin
                    if (pend) begin
                        if (p_cmd == MRead && cyc == p_ack - 1) m_rd[p_own] = p_rd;
                        if (cyc == p_ack) begin
                            m_last = p_own;
                            pend   = 1'b0;
                        end
                    end else begin
                        r0 = (m0_cmd == MRead) || (m0_cmd == MWrite);
                        r1 = (m1_cmd == MRead) || (m1_cmd == MWrite);
                        if (r0 || r1) begin
                            w       = (r0 && r1) ? !m_last : r1;
                            pend    = 1'b1;
                            p_grant = cyc;
                            p_own   = w;
                            m_own   = w;
                            p_cmd   = w ? m1_cmd : m0_cmd;
                            p_addr  = w ? m1_addr : m0_addr;
                            p_wd    = w ? m1_wdata : m0_wdata;
                            p_rd    = shadow[p_addr];
                            p_ack   = cyc + 2 + ((p_cmd == MRead) ? int'(L) : 0);
                        end
                    end
                end
                cyc++;
            end
        end

        // Every-cycle comparison against the model
        initial begin
            logic [1:0] ec;
            forever begin
                @(negedge clk);
                if (mvalid) begin
                    ec = (pend && cyc > p_grant && cyc < p_ack) ? p_cmd : MNone;
                    chk(L, "busy", busy, pend);
                    chk(L, "m0_ack", m0_ack, pend && cyc == p_ack && !p_own);
                    chk(L, "m1_ack", m1_ack, pend && cyc == p_ack && p_own);
                    chk(L, "mem_cmd", mem_cmd, ec);
                    if (ec != MNone) chk(L, "mem_addr", mem_addr, p_addr);
                    if (ec == MWrite) chk(L, "mem_wdata", mem_wdata, p_wd);
                    chk(L, "owner", owner, m_own);
                    chk(L, "m0_rdata", m0_rdata, m_rd[0]);
                    chk(L, "m1_rdata", m1_rdata, m_rd[1]);
                end
            end
        end

        task automatic nxt();
            @(posedge clk);
            #1;
        endtask

        initial begin
            int   t0;
            int   p;
            int   d;
            logic e0, e1;
            m0_cmd = MNone; m0_addr = '0; m0_wdata = '0;
            m1_cmd = MNone; m1_addr = '0; m1_wdata = '0;
            rst_n  = 1'b0;
            repeat (3) nxt();
            rst_n = 1'b1;

            // Write 16'hABCD to address 5 from m0
            t0 = cyc;
            m0_cmd = MWrite; m0_addr = 9'h005; m0_wdata = 16'hABCD;
            nxt(); @(negedge clk);
            chk(L, "wr issue cmd", mem_cmd, MWrite);
            chk(L, "wr issue addr", mem_addr, 9'h005);
            chk(L, "wr issue busy", busy, 1'b1);
            nxt(); @(negedge clk);
            chk(L, "wr ack", m0_ack, 1'b1);
            chk(L, "wr cmd cleared", mem_cmd, MNone);
            chk(L, "ram[5]", ram[5], 16'hABCD);
            m0_cmd = MNone;
            nxt();

            // Read it back on m0
            m0_cmd = MRead; m0_addr = 9'h005;
            nxt(); @(negedge clk);
            chk(L, "rd issue cmd", mem_cmd, MRead);
            chk(L, "rd issue addr", mem_addr, 9'h005);
            for (int k = 0; k < int'(L); k++) begin
                nxt(); @(negedge clk);
                chk(L, "rd wait addr", mem_addr, 9'h005);
                chk(L, "rd wait no ack", m0_ack, 1'b0);
            end
            nxt(); @(negedge clk);
            chk(L, "rd ack", m0_ack, 1'b1);
            chk(L, "rd m0_rdata", m0_rdata, 16'hABCD);
            chk(L, "rd m1_rdata kept", m1_rdata, 16'h0000);
            m0_cmd = MNone;
            nxt();

            // m1 read withdrawn right after the grant still completes
            m1_cmd = MRead; m1_addr = 9'h005;
            nxt();
            m1_cmd = MNone;
            @(negedge clk);
            chk(L, "wd no early ack", m1_ack, 1'b0);
            for (int k = 0; k < int'(L); k++) begin
                nxt(); @(negedge clk);
                chk(L, "wd no early ack", m1_ack, 1'b0);
            end
            nxt(); @(negedge clk);
            chk(L, "wd m1_ack", m1_ack, 1'b1);
            chk(L, "wd m0 not acked", m0_ack, 1'b0);
            chk(L, "wd m1_rdata", m1_rdata, 16'hABCD);
            chk(L, "wd owner", owner, 1'b1);
            nxt();

            // Reserved command is never granted
            m0_cmd = 2'b11;
            repeat (5) begin
                nxt(); @(negedge clk);
                chk(L, "cmd11 busy", busy, 1'b0);
            end
            m0_cmd = MNone;
            nxt();

            // Reset while the read is in flight: no ack, everything cleared
            m0_cmd = MRead; m0_addr = 9'h006;
            nxt();
            m0_cmd = MNone;
            repeat ((L > 0) ? 1 : 0) nxt();
            rst_n = 1'b0;
            @(negedge clk);
            chk(L, "rst busy before", busy, 1'b1);
            nxt();
            rst_n = 1'b1;
            @(negedge clk);
            chk(L, "rst busy", busy, 1'b0);
            chk(L, "rst mem_cmd", mem_cmd, MNone);
            chk(L, "rst mem_addr", mem_addr, 9'h000);
            chk(L, "rst mem_wdata", mem_wdata, 16'h0000);
            chk(L, "rst m0_rdata", m0_rdata, 16'h0000);
            chk(L, "rst m1_rdata", m1_rdata, 16'h0000);
            chk(L, "rst owner", owner, 1'b0);
            repeat (L + 3) begin
                chk(L, "rst no ack", m0_ack | m1_ack, 1'b0);
                nxt(); @(negedge clk);
            end

            // Both masters read continuously from reset: strict alternation starting with m0
            rst_n = 1'b0;
            nxt();
            rst_n = 1'b1;
            t0 = cyc;
            p  = 3 + int'(L);
            m0_cmd = MRead; m0_addr = 9'h005;
            m1_cmd = MRead; m1_addr = 9'h006;
            for (d = 0; d < 4 * p; d++) begin
                @(negedge clk);
                e0 = (d % p == 2 + int'(L)) && ((d / p) % 2 == 0);
                e1 = (d % p == 2 + int'(L)) && ((d / p) % 2 == 1);
                chk(L, "alt m0_ack", m0_ack, e0);
                chk(L, "alt m1_ack", m1_ack, e1);
                if (e1) chk(L, "alt m1_rdata", m1_rdata, init_word(6));
                nxt();
            end
            m0_cmd = MNone;
            m1_cmd = MNone;
            repeat (L + 4) nxt();

            // Randomized masters obeying the hold-until-ack rule
            for (int i = 0; i < 1500; i++) begin
                @(negedge clk);
                e0 = m0_ack;
                e1 = m1_ack;
                if (e0 || (!(m0_cmd == MRead || m0_cmd == MWrite) && $urandom_range(0, 2) == 0))
                begin
                    m0_cmd   = rnd_cmd();
                    m0_addr  = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
                    m0_wdata = DW'($urandom);
                end
                if (e1 || (!(m1_cmd == MRead || m1_cmd == MWrite) && $urandom_range(0, 2) == 0))
                begin
                    m1_cmd   = rnd_cmd();
                    m1_addr  = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
                    m1_wdata = DW'($urandom);
                end
            end
            @(negedge clk);
            m0_cmd = MNone;
            m1_cmd = MNone;
            repeat (L + 6) nxt();
            fin = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < 60000; i++) begin
            @(posedge clk);
            if (g_inst[0].fin && g_inst[1].fin && g_inst[2].fin) break;
        end
        checks++;
        if (!(g_inst[0].fin && g_inst[1].fin && g_inst[2].fin)) begin
            errors++;
            $display("FAIL timeout: stimulus did not complete within the cycle budget");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
